andport_checker: RTL and testbench

- Sequential response analyzer for the 2-input AND gate. It is the receive/check end of the gate's stimulus-and-observe flow.
- Accepts sampled (a, b, out) triples over a valid/ready handshake. Compares each out against a&b, counts vectors and mismatches, and tracks truth-table coverage.
- Reports a latched pass/fail verdict at the end of a session.
- Sits beside the andport instance, fed by the stimulus driver or a sampling stage.

---
 rtl/andport_checker.sv | 109 ++++++++++
 tb/tb_andport_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/andport_checker.sv
// rtl/andport_checker.sv - response checker for a 2-input AND gate with session verdict
// Optional: ANDCHK_AUTOSTOP_EN ends the session once all four input combinations are seen.
module andport_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic             smp_a,
    input  logic             smp_b,
    input  logic             smp_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             acc;
    logic             mis;
    logic             auto_stop;
    logic [CNT_W-1:0] vec_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic [3:0]       cov_nxt;

    assign smp_ready = (state == RUN);
    assign busy      = smp_ready;

    assign acc = smp_valid && smp_ready;
    assign mis = smp_out != (smp_a & smp_b);

    // Post-sample values, so a sample accepted alongside stop still shapes the verdict
    assign vec_nxt = (acc && vec_cnt != CNT_MAX) ? vec_cnt + 1'b1 : vec_cnt;
    assign err_nxt = (acc && mis && err_cnt != CNT_MAX) ? err_cnt + 1'b1 : err_cnt;
    assign cov_nxt = acc ? (cov | (4'b0001 << {smp_a, smp_b})) : cov;

`ifdef ANDCHK_AUTOSTOP_EN
    assign auto_stop = acc && (cov_nxt == 4'hF);
`else
    assign auto_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop || auto_stop) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_cnt         <= '0;
            err_cnt         <= '0;
            cov             <= 4'h0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (state == RUN) begin
            vec_cnt <= vec_nxt;
            err_cnt <= err_nxt;
            cov     <= cov_nxt;
            if (acc && mis && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= vec_cnt;
            end
            if (state_nxt == DONE) begin
                done <= 1'b1;
                pass <= (err_nxt == '0) && (cov_nxt == 4'hF) && (vec_nxt != '0);
            end
        end else if (start) begin
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_cnt         <= '0;
            err_cnt         <= '0;
            cov             <= 4'h0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end
    end

endmodule

// File: tb/tb_andport_checker.sv
// tb/tb_andport_checker.sv - self-checking bench for andport_checker (CNT_W=8 and CNT_W=3 instances)
module tb_andport_checker;

`ifdef ANDCHK_AUTOSTOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, stop, smp_valid, smp_a, smp_b, smp_out;

    logic       rdy8, busy8, done8, pass8, fev8;
    logic [7:0] vec8, err8, fei8;
    logic [3:0] cov8;
    logic       rdy3, busy3, done3, pass3, fev3;
    logic [2:0] vec3, err3, fei3;
    logic [3:0] cov3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    andport_checker #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .smp_valid(smp_valid), .smp_ready(rdy8),
        .smp_a(smp_a), .smp_b(smp_b), .smp_out(smp_out),
        .busy(busy8), .done(done8), .pass(pass8),
        .vec_cnt(vec8), .err_cnt(err8), .cov(cov8),
        .first_err_valid(fev8), .first_err_idx(fei8)
    );

    andport_checker #(.CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .smp_valid(smp_valid), .smp_ready(rdy3),
        .smp_a(smp_a), .smp_b(smp_b), .smp_out(smp_out),
        .busy(busy3), .done(done3), .pass(pass3),
        .vec_cnt(vec3), .err_cnt(err3), .cov(cov3),
        .first_err_valid(fev3), .first_err_idx(fei3)
    );

    // Session model: raw unbounded counts, saturation applied only when viewed at a width
    int       m_state = 0;
    bit       armed = 1'b0;
    int       vcount, ecount, fe_raw;
    bit       m_fev, m_done, m_pass;
    logic [3:0] m_cov;

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic m_clear();
        vcount = 0; ecount = 0; fe_raw = 0;
        m_fev = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_cov = 4'h0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_clear();
            armed = 1'b1;
        end else if (m_state == 1) begin
            if (smp_valid) begin
                if (smp_out != (smp_a & smp_b)) begin
                    if (!m_fev) begin
                        m_fev  = 1'b1;
                        fe_raw = vcount;
                    end
                    ecount++;
                end
                vcount++;
                m_cov[{smp_a, smp_b}] = 1'b1;
            end
            if (stop || (AUTO && smp_valid && m_cov == 4'hF)) begin
                m_state = 2;
                m_done  = 1'b1;
                m_pass  = (ecount == 0) && (m_cov == 4'hF) && (vcount != 0);
            end
        end else if (start) begin
            m_state = 1;
            m_clear();
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("ready8", int'(rdy8), int'(m_state == 1));
            chk("busy8",  int'(busy8), int'(m_state == 1));
            chk("done8",  int'(done8), int'(m_done));
            chk("pass8",  int'(pass8), int'(m_pass));
            chk("vec8",   int'(vec8),  sat(vcount, 8));
            chk("err8",   int'(err8),  sat(ecount, 8));
            chk("cov8",   int'(cov8),  int'(m_cov));
            chk("fev8",   int'(fev8),  int'(m_fev));
            chk("fei8",   int'(fei8),  sat(fe_raw, 8));
            chk("ready3", int'(rdy3), int'(m_state == 1));
            chk("done3",  int'(done3), int'(m_done));
            chk("pass3",  int'(pass3), int'(m_pass));
            chk("vec3",   int'(vec3),  sat(vcount, 3));
            chk("err3",   int'(err3),  sat(ecount, 3));
            chk("cov3",   int'(cov3),  int'(m_cov));
            chk("fev3",   int'(fev3),  int'(m_fev));
            chk("fei3",   int'(fei3),  sat(fe_raw, 3));
        end
    end

    task automatic cyc(input logic st, input logic sp, input logic v,
                       input logic a, input logic b, input logic o);
        @(negedge clk);
        rst = 1'b0; start = st; stop = sp; smp_valid = v;
        smp_a = a; smp_b = b; smp_out = o;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; stop = 0; smp_valid = 0; smp_a = 0; smp_b = 0; smp_out = 0;
        @(negedge clk);
        @(negedge clk);
        chk("lit_reset_ready", int'(rdy8), 0);
        chk("lit_reset_done",  int'(done8), 0);
        chk("lit_reset_vec",   int'(vec8), 0);
        idle();

        // 1: all four combinations correct
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        chk("lit1_done", int'(done8), 1);
        chk("lit1_vec",  int'(vec8), 4);
        chk("lit1_cov",  int'(cov8), 15);
        chk("lit1_pass", int'(pass8), 1);
        chk("lit1_fev",  int'(fev8), 0);

        // 2: third sample wrong
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 1);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        chk("lit2_err",  int'(err8), 1);
        chk("lit2_fev",  int'(fev8), 1);
        chk("lit2_fei",  int'(fei8), 2);
        chk("lit2_pass", int'(pass8), 0);

        // 3: missing combination {1,0}, then empty session
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        chk("lit3_cov",  int'(cov8), 4'b1011);
        chk("lit3_pass", int'(pass8), 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        chk("lit3e_vec",  int'(vec8), 0);
        chk("lit3e_pass", int'(pass8), 0);
        chk("lit3e_done", int'(done8), 1);

        // 4: ten correct samples, stop together with the tenth
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, (i == 9), 1, i[1], i[0], i[1] & i[0]);
        end
        idle();
        chk("lit4_vec3",  int'(vec3), AUTO ? 4 : 7);
        chk("lit4_vec8",  int'(vec8), AUTO ? 4 : 10);
        chk("lit4_pass3", int'(pass3), 1);

        // error counter saturation at CNT_W=3
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        chk("litsat_err3", int'(err3), 7);
        chk("litsat_err8", int'(err8), 9);
        chk("litsat_pass", int'(pass3), 0);

        // 5: reset mid-RUN, then samples ignored in IDLE
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 1);
        @(negedge clk);
        rst = 1'b1; start = 0; stop = 0; smp_valid = 1; smp_a = 1; smp_b = 0; smp_out = 0;
        idle();
        chk("lit5_ready", int'(rdy8), 0);
        chk("lit5_vec",   int'(vec8), 0);
        chk("lit5_cov",   int'(cov8), 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 1, 0);
        idle();
        chk("lit5_vec_idle", int'(vec8), 0);

        // 6: four correct samples back-to-back without stop
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 1, 1);
        idle();
        chk("lit6_done", int'(done8), AUTO ? 1 : 0);
        chk("lit6_busy", int'(busy8), AUTO ? 0 : 1);
        chk("lit6_pass", int'(pass8), AUTO ? 1 : 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        chk("lit6_final_pass", int'(pass8), 1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
